// File: rtl/bit8_1to2demux_buf.sv
// Buffered 1-to-2 byte demultiplexer: one input stream, two output channels,
// each behind its own small FIFO with a valid/ready handshake and a wrapping
// count of the bytes it has accepted.

// One output channel: FIFO storage, occupancy tracking and transfer counter.
module bit8_1to2demux_chan #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [OW-1:0]               occ;
  logic                        do_pop;

  assign full   = (occ == OCC_FULL);
  assign valid  = (occ != '0);
  // Pops while empty are dropped here so the consumer may hold ready freely.
  assign do_pop = pop && valid;
  // Idle channels drive zero rather than stale storage.
  assign rdata  = valid ? mem[rd_ptr] : '0;

  // Storage needs no reset: it is only visible while occ says it is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and counter; pointers wrap at DEPTH (power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        cnt    <= cnt + CW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end
endmodule

// Top: steers each input byte to the channel named by in_sel.
module bit8_1to2demux_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CW-1:0]    cnt0,
  output logic [CW-1:0]    cnt1
);
  localparam int NCH = 2;

  logic [NCH-1:0]            full, valid, push, ready;
  logic [NCH-1:0][WIDTH-1:0] rdata;
  logic [NCH-1:0][CW-1:0]    cnt;

  // A full target stalls the input even if the other channel has room, and a
  // same-cycle pop does not open a full FIFO (no pass-through).
  assign in_ready = !full[in_sel];
  assign ready    = {out1_ready, out0_ready};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign push[i] = in_valid && in_ready && (in_sel == 1'(i));

    bit8_1to2demux_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_chan (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .wdata (in_data),
      .pop   (ready[i]),
      .full  (full[i]),
      .valid (valid[i]),
      .rdata (rdata[i]),
      .cnt   (cnt[i])
    );
  end

  assign out0_data  = rdata[0];
  assign out1_data  = rdata[1];
  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];
endmodule

// File: tb/tb_bit8_1to2demux_buf.sv
// Bench for bit8_1to2demux_buf: directed scenarios plus a randomized run,
// all compared against a queue-based model of the two channels.
module tb_bit8_1to2demux_buf;
  localparam int DEPTH = 2;

  logic       clk, reset;
  logic [7:0] in_data;
  logic       in_sel, in_valid, in_ready;
  logic [7:0] out0_data, out1_data;
  logic       out0_valid, out1_valid, out0_ready, out1_ready;
  logic [7:0] cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  bit8_1to2demux_buf #(.WIDTH(8), .DEPTH(DEPTH), .CW(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per channel plus byte counters.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] m_cnt0, m_cnt1;

  function automatic void model_clear();
    q0.delete(); q1.delete();
    m_cnt0 = 0; m_cnt1 = 0;
  endfunction

  function automatic logic exp_ready(input logic sel);
    return sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
  endfunction

  // Expected {out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1}.
  function automatic logic [33:0] model_obs();
    logic [7:0] h0, h1;
    h0 = (q0.size() > 0) ? q0[0] : 8'h00;
    h1 = (q1.size() > 0) ? q1[0] : 8'h00;
    return {q0.size() > 0, h0, q1.size() > 0, h1, m_cnt0, m_cnt1};
  endfunction

  function automatic void model_step();
    logic acc, p0, p1;
    acc = in_valid && exp_ready(in_sel);
    p0  = out0_ready && (q0.size() > 0);
    p1  = out1_ready && (q1.size() > 0);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (in_sel) begin q1.push_back(in_data); m_cnt1 = m_cnt1 + 8'd1; end
      else        begin q0.push_back(in_data); m_cnt0 = m_cnt0 + 8'd1; end
    end
  endfunction

  function automatic logic [33:0] dut_obs();
    return {out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1};
  endfunction

  // One clock: model advances on the edge, bench returns at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; in_sel = 0; in_data = 0;
    out0_ready = 0; out1_ready = 0;
    @(negedge clk);
    reset = 0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_obs() !== 34'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", dut_obs(), 34'h0);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_routing();
    do_reset();
    in_valid = 1; in_sel = 0; in_data = 8'hA5;
    cycle();
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 8'hA5) begin
      bad++; $display("FAIL route_ch0 got=%b/%h want=1/a5", out0_valid, out0_data);
    end
    in_sel = 1; in_data = 8'h3C;
    cycle();
    in_valid = 0;
    total++;
    if (dut_obs() !== {1'b1, 8'hA5, 1'b1, 8'h3C, 8'd1, 8'd1}) begin
      bad++; $display("FAIL route_both got=%h want=%h", dut_obs(),
                      {1'b1, 8'hA5, 1'b1, 8'h3C, 8'd1, 8'd1});
    end
  endtask

  task automatic test_fill();
    do_reset();
    in_valid = 1; in_sel = 0; in_data = 8'h01;
    cycle();
    in_data = 8'h02;
    cycle();
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL full_ready_sel0 got=%b want=0", in_ready);
    end
    in_sel = 1; #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL full_ready_sel1 got=%b want=1", in_ready);
    end
    in_sel = 0; in_data = 8'h03;
    cycle();
    total++;
    if (cnt0 !== 8'd2 || out0_data !== 8'h01 || dut_obs() !== model_obs()) begin
      bad++; $display("FAIL full_stall got=%h want=%h", dut_obs(), model_obs());
    end
    out0_ready = 1;
    cycle();
    total++;
    if (out0_data !== 8'h02 || cnt0 !== 8'd2) begin
      bad++; $display("FAIL drain_first got=%h/%0d want=02/2", out0_data, cnt0);
    end
    cycle();
    in_valid = 0;
    total++;
    if (out0_data !== 8'h03 || cnt0 !== 8'd3 || dut_obs() !== model_obs()) begin
      bad++; $display("FAIL drain_accept got=%h want=%h", dut_obs(), model_obs());
    end
    cycle();
    total++;
    if (out0_valid !== 1'b0 || out0_data !== 8'h00) begin
      bad++; $display("FAIL drain_empty got=%b/%h want=0/00", out0_valid, out0_data);
    end
    out0_ready = 0;
  endtask

  task automatic test_simul();
    do_reset();
    in_valid = 1; in_sel = 1; in_data = 8'h10;
    cycle();
    in_data = 8'h11; out1_ready = 1;
    cycle();
    in_valid = 0;
    total++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h11 || cnt1 !== 8'd2) begin
      bad++; $display("FAIL simul_head got=%b/%h/%0d want=1/11/2", out1_valid, out1_data, cnt1);
    end
    cycle();
    total++;
    if (out1_valid !== 1'b0 || dut_obs() !== model_obs()) begin
      bad++; $display("FAIL simul_occ1 got=%h want=%h", dut_obs(), model_obs());
    end
    out1_ready = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid = 1; in_sel = 1; out1_ready = 1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'($urandom);
      cycle();
      if (i == 254) begin
        total++;
        if (cnt1 !== 8'd255) begin
          bad++; $display("FAIL wrap_255 got=%0d want=255", cnt1);
        end
      end
    end
    in_valid = 0;
    total++;
    if (cnt1 !== 8'd0 || cnt0 !== 8'd0 || dut_obs() !== model_obs()) begin
      bad++; $display("FAIL wrap_zero got=%h want=%h", dut_obs(), model_obs());
    end
    out1_ready = 0;
  endtask

  task automatic test_random();
    logic acc;
    int   errs = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      acc = in_valid && exp_ready(in_sel);
      // Keep a stalled byte stable; otherwise pick a fresh one.
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 1'($urandom);
        in_data  = 8'($urandom);
      end
      out0_ready = ($urandom_range(0, 2) == 0);
      out1_ready = ($urandom_range(0, 2) == 0);
      #1;
      total++;
      if (in_ready !== exp_ready(in_sel)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_in_ready cyc=%0d got=%b want=%b", i, in_ready, exp_ready(in_sel));
      end
      cycle();
      total++;
      if (dut_obs() !== model_obs()) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_obs cyc=%0d got=%h want=%h", i, dut_obs(), model_obs());
      end
    end
    in_valid = 0; out0_ready = 0; out1_ready = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_sel = 1'(i); in_data = 8'($urandom_range(1, 255));
      cycle();
    end
    in_valid = 0;
    total++;
    if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
      bad++; $display("FAIL arst_prefill got=%b%b want=11", out0_valid, out1_valid);
    end
    #2 reset = 1;
    #1;
    total++;
    if (dut_obs() !== 34'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL arst_clear got=%h/%b want=0/1", dut_obs(), in_ready);
    end
    @(negedge clk);
    reset = 0;
    model_clear();
    in_valid = 1; in_sel = 0; in_data = 8'h55;
    cycle();
    in_valid = 0;
    total++;
    if (dut_obs() !== {1'b1, 8'h55, 1'b0, 8'h00, 8'd1, 8'd0}) begin
      bad++; $display("FAIL arst_after got=%h want=%h", dut_obs(),
                      {1'b1, 8'h55, 1'b0, 8'h00, 8'd1, 8'd0});
    end
    out0_ready = 1;
    cycle();
    total++;
    if (out0_valid !== 1'b0) begin
      bad++; $display("FAIL arst_single got=%b want=0", out0_valid);
    end
    out0_ready = 0;
  endtask

  initial begin
    clk = 0; reset = 1;
    in_valid = 0; in_sel = 0; in_data = 0; out0_ready = 0; out1_ready = 0;
    model_clear();
    test_reset();
    test_routing();
    test_fill();
    test_simul();
    test_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bit8_1to2demux_buf.md
Name: bit8_1to2demux_buf

Overview:
- Buffered 8-bit 1-to-2 demultiplexer. It is the inverse of the team's 8-bit 2-to-1 mux.
- Accepts one byte stream with a per-byte select and steers each byte into one of two output channels.
- Each output channel has its own small FIFO and a valid/ready handshake.
- Sits on the lab datapath wherever one producer feeds two consumers. Includes per-channel transfer counters for debug.

Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 2: entries per channel FIFO. Must be a power of 2 and at least 2.
- CW, 8: width of each transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  byte to route.
- in_sel  input  1  destination: 0 routes to channel 0, 1 routes to channel 1.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  the FIFO selected by in_sel can accept a byte.
- out0_data  output  WIDTH  channel 0 head byte.
- out0_valid  output  1  channel 0 FIFO not empty.
- out0_ready  input  1  channel 0 consumer accepts head.
- out1_data  output  WIDTH  channel 1 head byte.
- out1_valid  output  1  channel 1 FIFO not empty.
- out1_ready  input  1  channel 1 consumer accepts head.
- cnt0  output  CW  bytes accepted into channel 0, wrapping.
- cnt1  output  CW  bytes accepted into channel 1, wrapping.

Behaviour:
- Reset (async assert, values take effect immediately):
  - Both FIFO occupancies, read pointers and write pointers go to 0.
  - cnt0 and cnt1 go to 0.
  - out0_valid, out1_valid, out0_data and out1_data go to 0.
  - in_ready equals !full of the selected FIFO, which is 1 after reset.
- Each channel FIFO has occupancy occ in 0..DEPTH.
  - Empty when occ == 0; full when occ == DEPTH.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- in_ready is combinational: in_ready = !full[in_sel]. It depends only on in_sel and FIFO state, never on in_valid.
- Push: on a rising edge with in_valid && in_ready, write in_data into FIFO[in_sel] at its wr_ptr, advance wr_ptr, increment occ, and increment cnt[in_sel]. The counter wraps from 2^CW-1 to 0.
- outN_valid = (occN != 0).
- outN_data = mem[rd_ptr] when outN_valid, otherwise 0.
- Pop: on a rising edge with outN_valid && outN_ready, advance rd_ptr and decrement occ.
- Latency: no combinational path from in_data to outN_data. A byte pushed at edge k appears on outN_data/outN_valid after edge k, so it is first consumable at edge k+1.
- Simultaneous push and pop on the same channel:
  - occ unchanged; both pointers advance.
  - When full, in_ready is 0 even if a pop occurs the same cycle. There is no pass-through to a full FIFO.
- Push to one channel while the other channel pops: the two operations are independent.
- Pop on empty (outN_ready while !outN_valid): ignored, no state change.
- Byte ordering: strict FIFO order within a channel. No ordering relation between channels.
- in_valid held with a full target: the byte stays pending. Upstream must hold in_data/in_sel stable until accepted.
- A full target stalls the input even if the other channel has space. There is no head-of-line bypass.
- Reset mid-operation: all buffered bytes are discarded. Counters and valids clear asynchronously.
- in_data, in_sel and outN_ready are don't-care while reset is high.

Test Plan:
- Reset then idle: reset pulse with in_valid=0 → out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0, in_ready=1.
- Basic routing: push 0xA5 with sel=0, then 0x3C with sel=1, with out0_ready=out1_ready=0.
  - One edge after each push, the matching channel shows the byte: out0_data=0xA5 and out1_data=0x3C, both valid.
  - cnt0=1, cnt1=1.
- Fill and back-pressure on channel 0:
  - Push 0x01 then 0x02 with sel=0 and out0_ready=0 → in_ready=0 while in_sel=0, 1 while in_sel=1.
  - A third push of 0x03 with sel=0 is not accepted and cnt0 stays 2.
  - Raise out0_ready → pops 0x01 then 0x02 in order, then 0x03 is accepted.
- Simultaneous push/pop: channel 1 holds 1 entry (0x10); push 0x11 with sel=1 while out1_ready=1 → 0x10 consumed, occ stays 1, next head is 0x11.
- Counter wrap: accept 256 bytes with sel=1 and out1_ready=1 → cnt1 returns to 0x00 and cnt0 is unchanged.
- Async reset mid-stream: assert reset between edges while both channels are non-empty → valids, data and counters are 0 before the next edge. After release, a push of 0x55 with sel=0 appears as the only channel 0 entry.
